// File: rtl/de2i_150_qsys_nios2_cpu_debug_cmd_sched_pkg.sv
// Shared command codes, queue entry type and routing helper for the
// Nios II debug command scheduler.
package de2i_150_qsys_nios2_cpu_debug_cmd_sched_pkg;

  localparam int JDO_W       = 38;
  localparam int CODE_W      = 3;
  localparam int NUM_STROBES = 6;

  localparam logic [CODE_W-1:0] CMD_OCIMEM_A  = 3'd0;
  localparam logic [CODE_W-1:0] CMD_OCIMEM_B  = 3'd1;
  localparam logic [CODE_W-1:0] CMD_BREAK_A   = 3'd2;
  localparam logic [CODE_W-1:0] CMD_BREAK_B   = 3'd3;
  localparam logic [CODE_W-1:0] CMD_BREAK_C   = 3'd4;
  localparam logic [CODE_W-1:0] CMD_TRACECTRL = 3'd5;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [JDO_W-1:0]  data;
  } cmd_entry_t;

  function automatic logic is_mem_code(input logic [CODE_W-1:0] code);
    return (code == CMD_OCIMEM_A) || (code == CMD_OCIMEM_B);
  endfunction

endpackage

// File: rtl/de2i_150_qsys_nios2_cpu_debug_cmd_fifo.sv
// In-order command queue: extra-bit pointers give occupancy as wr - rd and
// let a push land on a full queue when the head pops in the same cycle.
module de2i_150_qsys_nios2_cpu_debug_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 41,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   level_o,
  output logic          push_ok_o,
  output logic          empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         full;
  logic         pop_ok;

  assign level_o   = wr_q - rd_q;
  assign empty_o   = (wr_q == rd_q);
  assign full      = (level_o == (AW+1)'(DEPTH));
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full || pop_ok);
  assign head_o    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok_o) wr_d = wr_q + 1'b1;
    if (pop_ok)    rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; outputs are masked while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/de2i_150_qsys_nios2_cpu_debug_cmd_sched.sv
// Debug command scheduler: queues take_action strobes and issues them in order
// on the mem/brk channels. Optional head timeout: DEBUG_CMD_TIMEOUT_EN.
module de2i_150_qsys_nios2_cpu_debug_cmd_sched #(
  parameter int FIFO_DEPTH     = 4,
  parameter int JDO_W          = 38,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [JDO_W-1:0]              jdo,
  input  logic                          take_action_ocimem_a,
  input  logic                          take_action_ocimem_b,
  input  logic                          take_action_break_a,
  input  logic                          take_action_break_b,
  input  logic                          take_action_break_c,
  input  logic                          take_action_tracectrl,
  input  logic                          debugack,
  input  logic                          mem_ready,
  input  logic                          brk_ready,
  input  logic                          err_clr,
  output logic                          mem_valid,
  output logic                          mem_code,
  output logic [JDO_W-1:0]              mem_data,
  output logic                          brk_valid,
  output logic [1:0]                    brk_code,
  output logic [JDO_W-1:0]              brk_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf_err,
  output logic                          col_err,
  output logic                          tmo_err
);

  import de2i_150_qsys_nios2_cpu_debug_cmd_sched_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (JDO_W != de2i_150_qsys_nios2_cpu_debug_cmd_sched_pkg::JDO_W) begin : g_bad_jdo
    $error("JDO_W must match the package queue entry width");
  end

  logic [NUM_STROBES-1:0] strobe;
  logic [CODE_W-1:0]      push_code;
  logic                   push;
  logic                   col_evt;
  logic                   ovf_evt;
  cmd_entry_t             push_entry;
  cmd_entry_t             head;
  logic [LW-1:0]          fifo_level;
  logic                   push_ok;
  logic                   fifo_empty;
  logic                   head_mem;
  logic                   hs_pop;
  logic                   tmo_pop;
  logic                   pop;
  logic                   ovf_q, ovf_d;
  logic                   col_q, col_d;
  logic                   tmo_q, tmo_d;

  assign strobe = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                   take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};
  assign push    = |strobe;
  assign col_evt = |(strobe & (strobe - 6'd1));

  // Walk from the highest code down so the lowest asserted code wins.
  always_comb begin
    push_code = CMD_OCIMEM_A;
    for (int i = NUM_STROBES - 1; i >= 0; i--) begin
      if (strobe[i]) push_code = CODE_W'(i);
    end
  end

  assign push_entry = {push_code, jdo};

  de2i_150_qsys_nios2_cpu_debug_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(cmd_entry_t))
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .level_o     (fifo_level),
    .push_ok_o   (push_ok),
    .empty_o     (fifo_empty)
  );

  assign head_mem  = is_mem_code(head.code);
  assign mem_valid = !fifo_empty && head_mem && debugack;
  assign brk_valid = !fifo_empty && !head_mem;
  assign mem_code  = !fifo_empty && head_mem && head.code[0];
  // Codes 2..5 map onto 0..3 by subtracting 2 in the low two bits.
  assign brk_code  = brk_valid ? (head.code[1:0] - 2'd2) : 2'd0;
  assign mem_data  = fifo_empty ? '0 : head.data;
  assign brk_data  = fifo_empty ? '0 : head.data;

  assign hs_pop = (mem_valid && mem_ready) || (brk_valid && brk_ready);
  assign pop    = hs_pop || tmo_pop;

  assign level = fifo_level;
  assign busy  = !fifo_empty;

`ifdef DEBUG_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          stall;

  assign stall   = mem_valid && !mem_ready;
  assign tmo_pop = stall && (tmo_cnt_q == '0);

  always_comb begin
    tmo_cnt_d = TMO_LOAD;
    if (stall && !tmo_pop) tmo_cnt_d = tmo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= TMO_LOAD;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_pop = 1'b0;
`endif

  assign ovf_evt = push && !push_ok;

  // A new error event outranks err_clr in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    col_d = col_q;
    tmo_d = tmo_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      col_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (col_evt) col_d = 1'b1;
    if (tmo_pop) tmo_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      col_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      col_q <= col_d;
      tmo_q <= tmo_d;
    end
  end

  assign ovf_err = ovf_q;
  assign col_err = col_q;
  assign tmo_err = tmo_q;

endmodule

// File: tb/tb_de2i_150_qsys_nios2_cpu_debug_cmd_sched.sv
// Directed bench for the debug command scheduler; expected values are hand-computed.
module tb_de2i_150_qsys_nios2_cpu_debug_cmd_sched;

  localparam int DEPTH = 4;
  localparam int JW    = 38;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [JW-1:0] jdo;
  logic          ta_ocimem_a, ta_ocimem_b, ta_break_a, ta_break_b, ta_break_c, ta_tracectrl;
  logic          debugack, mem_ready, brk_ready, err_clr;
  logic          mem_valid, mem_code, brk_valid, busy, ovf_err, col_err, tmo_err;
  logic [1:0]    brk_code;
  logic [JW-1:0] mem_data, brk_data;
  logic [LW-1:0] level;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  de2i_150_qsys_nios2_cpu_debug_cmd_sched #(
    .FIFO_DEPTH     (DEPTH),
    .JDO_W          (JW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .jdo                   (jdo),
    .take_action_ocimem_a  (ta_ocimem_a),
    .take_action_ocimem_b  (ta_ocimem_b),
    .take_action_break_a   (ta_break_a),
    .take_action_break_b   (ta_break_b),
    .take_action_break_c   (ta_break_c),
    .take_action_tracectrl (ta_tracectrl),
    .debugack              (debugack),
    .mem_ready             (mem_ready),
    .brk_ready             (brk_ready),
    .err_clr               (err_clr),
    .mem_valid             (mem_valid),
    .mem_code              (mem_code),
    .mem_data              (mem_data),
    .brk_valid             (brk_valid),
    .brk_code              (brk_code),
    .brk_data              (brk_data),
    .busy                  (busy),
    .level                 (level),
    .ovf_err               (ovf_err),
    .col_err               (col_err),
    .tmo_err               (tmo_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    ta_ocimem_a  = 1'b0;
    ta_ocimem_b  = 1'b0;
    ta_break_a   = 1'b0;
    ta_break_b   = 1'b0;
    ta_break_c   = 1'b0;
    ta_tracectrl = 1'b0;
  endtask

  task automatic set_strobe(input int code);
    case (code)
      0: ta_ocimem_a  = 1'b1;
      1: ta_ocimem_b  = 1'b1;
      2: ta_break_a   = 1'b1;
      3: ta_break_b   = 1'b1;
      4: ta_break_c   = 1'b1;
      default: ta_tracectrl = 1'b1;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int push_codes[5];
    int drain_codes[4];
    logic [JW-1:0] drain_data[4];
    int cnt;

    push_codes  = '{1, 2, 4, 5, 0};
    drain_codes = '{0, 2, 3, 1};
    drain_data  = '{38'h101, 38'h102, 38'h103, 38'h2AA};

    reset_n = 1'b0;
    jdo = '0;
    clear_strobes();
    debugack = 1'b0; mem_ready = 1'b0; brk_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();

    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valids", {mem_valid, brk_valid}, 0);
    check_eq("rst_codes", {mem_code, brk_code}, 0);
    check_eq("rst_data", {mem_data, brk_data}, 0);
    check_eq("rst_flags", {ovf_err, col_err, tmo_err}, 0);
    reset_n = 1'b1;
    tick();

    // Single break_b command on a ready brk consumer
    jdo = 38'h15_5555_5555; ta_break_b = 1'b1; brk_ready = 1'b1;
    tick(); clear_strobes();
    check_eq("a_brk_valid", brk_valid, 1);
    check_eq("a_brk_code", brk_code, 1);
    check_eq("a_brk_data", brk_data, 38'h15_5555_5555);
    check_eq("a_mem_valid", mem_valid, 0);
    check_eq("a_busy", busy, 1);
    tick();
    check_eq("a_busy_after", busy, 0);
    check_eq("a_brk_valid_after", brk_valid, 0);
    brk_ready = 1'b0;

    // ocimem_a held back by debugack for 10 cycles
    jdo = 38'h0A_BCDE_F012; ta_ocimem_a = 1'b1; mem_ready = 1'b1;
    tick(); clear_strobes();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_valid) cnt++;
      tick();
    end
    check_eq("b_gated_cycles", cnt, 0);
    debugack = 1'b1;
    #1;
    check_eq("b_mem_valid", mem_valid, 1);
    check_eq("b_mem_code", mem_code, 0);
    check_eq("b_mem_data", mem_data, 38'h0A_BCDE_F012);
    tick();
    check_eq("b_mem_valid_after", mem_valid, 0);
    check_eq("b_busy_after", busy, 0);
    debugack = 1'b0; mem_ready = 1'b0;

    // Five pushes into a four-deep queue with both consumers stalled
    for (int k = 0; k < 5; k++) begin
      set_strobe(push_codes[k]);
      jdo = JW'(38'h100 + k);
      tick(); clear_strobes();
    end
    check_eq("c_level_full", level, 4);
    check_eq("c_ovf", ovf_err, 1);
    check_eq("c_col_clean", col_err, 0);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    check_eq("c_ovf_cleared", ovf_err, 0);
    check_eq("c_level_kept", level, 4);

    // Push and pop together on a full queue
    debugack = 1'b1; mem_ready = 1'b1;
    #1;
    check_eq("c_head_mem_valid", mem_valid, 1);
    check_eq("c_head_mem_code", mem_code, 1);
    check_eq("c_head_mem_data", mem_data, 38'h100);
    set_strobe(3); jdo = 38'h2AA;
    tick(); clear_strobes();
    mem_ready = 1'b0; debugack = 1'b0;
    check_eq("c_level_pushpop", level, 4);
    check_eq("c_ovf_pushpop", ovf_err, 0);

    brk_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("c_drain_valid", brk_valid, 1);
      check_eq("c_drain_code", brk_code, drain_codes[k]);
      check_eq("c_drain_data", brk_data, drain_data[k]);
      tick();
    end
    check_eq("c_level_drained", level, 0);
    check_eq("c_busy_drained", busy, 0);
    brk_ready = 1'b0;

    // Collision: ocimem_b + tracectrl -> ocimem_b wins
    jdo = 38'h3F_0000_0001; ta_ocimem_b = 1'b1; ta_tracectrl = 1'b1;
    tick(); clear_strobes();
    check_eq("d_level", level, 1);
    check_eq("d_col", col_err, 1);
    check_eq("d_mem_code", mem_code, 1);
    check_eq("d_brk_valid", brk_valid, 0);
    check_eq("d_mem_valid_noack", mem_valid, 0);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    check_eq("d_col_cleared", col_err, 0);
    err_clr = 1'b1; jdo = 38'h22; ta_break_a = 1'b1; ta_break_c = 1'b1;
    tick(); clear_strobes(); err_clr = 1'b0;
    check_eq("d_col_beats_clr", col_err, 1);
    check_eq("d_level2", level, 2);

    // Head-of-line blocking behind a stalled mem command
    debugack = 1'b1; brk_ready = 1'b1; mem_ready = 1'b0;
    #1;
    check_eq("e_mem_valid", mem_valid, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (brk_valid) cnt++;
      tick();
    end
    check_eq("e_brk_blocked", cnt, 0);
    check_eq("e_level", level, 2);
    check_eq("e_tmo_off", tmo_err, 0);
    debugack = 1'b0;
    #1;
    check_eq("e_mem_valid_drop", mem_valid, 0);
    debugack = 1'b1;
    #1;
    check_eq("e_mem_valid_back", mem_valid, 1);
    check_eq("e_mem_data_stable", mem_data, 38'h3F_0000_0001);

    // Asynchronous reset mid-transfer
    ta_break_b = 1'b1; jdo = 38'h33;
    tick(); clear_strobes();
    check_eq("f_level3", level, 3);
    check_eq("f_mem_valid", mem_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("f_level0", level, 0);
    check_eq("f_mem_valid0", mem_valid, 0);
    check_eq("f_busy0", busy, 0);
    check_eq("f_flags0", {ovf_err, col_err, tmo_err}, 0);
    check_eq("f_data0", mem_data, 0);
    tick();
    reset_n = 1'b1;
    brk_ready = 1'b0;
    tick();

`ifdef DEBUG_CMD_TIMEOUT_EN
    // Stalled mem head dropped after 16 cycles, brk command follows
    jdo = 38'h5; ta_ocimem_a = 1'b1;
    tick(); clear_strobes();
    jdo = 38'h6; ta_break_a = 1'b1;
    tick(); clear_strobes();
    cnt = 1;
    while (mem_valid && cnt < 40) begin
      cnt++;
      tick();
    end
    check_eq("g_stall_cycles", cnt, 16);
    check_eq("g_tmo_err", tmo_err, 1);
    check_eq("g_brk_valid", brk_valid, 1);
    check_eq("g_brk_data", brk_data, 38'h6);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/de2i_150_qsys_nios2_cpu_debug_cmd_sched.md
Name: de2i_150_qsys_nios2_cpu_debug_cmd_sched

Overview:
- Sits in the CPU clock domain between the debug-slave sysclk stage (take_action_* strobes plus the 38-bit jdo payload) and its consumers: the OCI memory unit and the break/trace-control unit.
- Captures each take_action strobe with its jdo word into a small in-order command queue.
- Issues commands over two ready/valid channels, mem and brk; ocimem commands are gated on debugack.
- Reports queue occupancy, busy and sticky error flags, so JTAG commands are never dropped silently when a consumer stalls.

Parameters:
- FIFO_DEPTH, 4, queue entries; power of two, 2..16.
- JDO_W, 38, jdo payload width.
- TIMEOUT_CYCLES, 1024, stall limit for the head mem command (used only with the optional feature).

Ports:
- clk  in  1  CPU system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  JDO_W  payload qualified by any take_action strobe
- take_action_ocimem_a  in  1  strobe, code 0
- take_action_ocimem_b  in  1  strobe, code 1
- take_action_break_a  in  1  strobe, code 2
- take_action_break_b  in  1  strobe, code 3
- take_action_break_c  in  1  strobe, code 4
- take_action_tracectrl  in  1  strobe, code 5
- debugack  in  1  CPU is in debug mode; required before any mem command is issued
- mem_ready  in  1  OCI memory unit accepts a command
- brk_ready  in  1  break/trace unit accepts a command
- err_clr  in  1  single-cycle pulse; clears the sticky error flags
- mem_valid  out  1  mem command valid
- mem_code  out  1  0 = ocimem_a, 1 = ocimem_b
- mem_data  out  JDO_W  mem payload
- brk_valid  out  1  brk command valid
- brk_code  out  2  0 = break_a, 1 = break_b, 2 = break_c, 3 = tracectrl
- brk_data  out  JDO_W  brk payload
- busy  out  1  queue non-empty
- level  out  $clog2(FIFO_DEPTH)+1  queue occupancy
- ovf_err  out  1  sticky: a command was dropped because the queue was full
- col_err  out  1  sticky: two or more strobes asserted in the same cycle
- tmo_err  out  1  sticky: head mem command timed out (0 when the optional feature is off)

Behaviour:
- Reset (asynchronous, reset_n low), all outputs 0: queue empty, level 0, busy 0, mem_valid 0, brk_valid 0, all codes and data 0, all error flags 0. Assertion mid-transfer aborts everything; the head command is lost and no partial handshake is retained.
- Capture:
  - Any strobe high in cycle N pushes {code[2:0], jdo} at the rising edge ending cycle N.
  - The command is visible on the outputs in cycle N+1 (latency 1) if the queue was empty.
  - Simultaneous strobes: the lowest code wins and is pushed; col_err is set.
- Full:
  - Push while level == FIFO_DEPTH with no pop in the same cycle: the command is dropped, ovf_err is set, level is unchanged.
  - Push and pop in the same cycle while full: both happen, level is unchanged, no error.
- Issue (strict in-order, head of queue only; head-of-line blocking is intended):
  - Head code 0..1: mem_valid = !empty && debugack. brk_valid = 0.
  - Head code 2..5: brk_valid = !empty. mem_valid = 0.
  - mem_data and brk_data both show the head payload; the channel that is not selected keeps valid 0.
  - Pop when (mem_valid && mem_ready) || (brk_valid && brk_ready).
  - Once valid is high, code and data stay stable until the pop.
  - If debugack falls while mem_valid is high, mem_valid drops to 0. The command stays queued and re-asserts when debugack returns.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. level = wr - rd, computed one bit wider than the pointers.
- err_clr: clears ovf_err, col_err and tmo_err. An error event in the same cycle as err_clr wins, and the flag stays set.
- busy = (level != 0), registered alongside level.

Optional Feature:
- Macro: DEBUG_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs while mem_valid && !mem_ready, and resets on pop or when mem_valid = 0.
  - When the counter reaches TIMEOUT_CYCLES - 1, the head is popped without handshake and tmo_err is set.
  - The next queued command appears the following cycle.
- Undefined: no counter, tmo_err is tied 0, and a stalled mem consumer stalls the queue indefinitely.

Decomposition:
- Shared package:
  - Command code constants CMD_OCIMEM_A..CMD_TRACECTRL (3-bit).
  - JDO_W.
  - The queue entry struct {code, data}.
  - A route helper function (is_mem_code).
- One natural sub-module: de2i_150_qsys_nios2_cpu_debug_cmd_fifo. It is a synchronous FIFO with async active-low reset that exposes head, level, push_ok and pop. The scheduler keeps priority encoding, routing, error flags and the timeout logic.

Test Plan:
- Single take_action_break_b with jdo = 38'h15_5555_5555, brk_ready = 1 -> next cycle brk_valid = 1, brk_code = 1, brk_data = 38'h15_5555_5555; popped; busy returns to 0 the cycle after.
- take_action_ocimem_a with debugack = 0 for 10 cycles, then debugack = 1, mem_ready = 1 -> mem_valid stays 0 for those 10 cycles, then pulses 1 cycle with mem_code = 0.
- Five back-to-back strobes, FIFO_DEPTH = 4, both readies 0 -> level = 4, ovf_err = 1; draining yields the first four codes in order.
- take_action_ocimem_b and take_action_tracectrl in the same cycle -> one entry with code 1, col_err = 1; err_clr pulse -> col_err = 0.
- Queue order mem, brk with mem_ready = 0 -> brk_valid stays 0 (head-of-line blocking). With DEBUG_CMD_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the mem head is dropped after 16 cycles, tmo_err = 1, and brk_valid rises the next cycle.
- reset_n low while level = 3 and mem_valid = 1 -> immediately level = 0, mem_valid = 0, all flags 0.
